// File: rtl/ipsxb_uart_tx_32bit.sv
// ipsxb_uart_tx_32bit
// Serializes a 32-bit word as four 8N1 UART bytes, least-significant byte
// first. Words arrive over a request/accept handshake from the control block.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   tx_data        word to send, held stable while tx_data_req is high
//   tx_data_req    word-available request
//   tx_data_valid  one-cycle accept pulse (word captured on this edge)
//   txd            serial output, idles high
//   busy           high from accept until the end of the last stop bit
//
// state | meaning
// IDLE  | line high, waiting for a request
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first, from the shift register
// STOP  | stop bit (high); loops back to START until all four bytes are sent
module ipsxb_uart_tx_32bit #(
  parameter int CLK_DIV_P = 72
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_data,
  input  logic        tx_data_req,
  output logic        tx_data_valid,
  output logic        txd,
  output logic        busy
);

  localparam int CW = $clog2(CLK_DIV_P);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV_P - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          baud_end;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    baud_end = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (tx_data_req) begin
          shift_d = tx_data;
          byte_d  = 2'd0;
          bit_d   = 3'd0;
          valid_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          // Eight shifts per byte leave the next byte in shift_q[7:0].
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shift_q <= 32'd0;
      txd_q   <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign txd           = txd_q;
  assign tx_data_valid = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ipsxb_uart_tx_32bit.sv
// Self-checking bench for ipsxb_uart_tx_32bit. Three instances cover the
// dividers 4, 2 and 72. The expected serial line is computed per cycle from
// the frame rules (bit slot = cycle / divider, ten slots per byte).
module tb_ipsxb_uart_tx_32bit;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  logic [2:0]  req;
  logic [31:0] data [3];
  logic [2:0]  txd_w, busy_w, valid_w;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ipsxb_uart_tx_32bit #(.CLK_DIV_P(4)) u_dut4 (
    .clk(clk), .rst(rst[0]), .tx_data(data[0]), .tx_data_req(req[0]),
    .tx_data_valid(valid_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));

  ipsxb_uart_tx_32bit #(.CLK_DIV_P(2)) u_dut2 (
    .clk(clk), .rst(rst[1]), .tx_data(data[1]), .tx_data_req(req[1]),
    .tx_data_valid(valid_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));

  ipsxb_uart_tx_32bit #(.CLK_DIV_P(72)) u_dut72 (
    .clk(clk), .rst(rst[2]), .tx_data(data[2]), .tx_data_req(req[2]),
    .tx_data_valid(valid_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));

  function automatic int div_of(input int s);
    if (s == 0) return 4;
    if (s == 1) return 2;
    return 72;
  endfunction

  // Expected line level t cycles after the accept edge.
  function automatic logic exp_txd(input logic [31:0] w, input int t, input int div);
    int slot, byte_i, pos;
    slot   = t / div;
    byte_i = slot / 10;
    pos    = slot % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[byte_i*8 + pos - 1];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sends one word on instance s and checks every cycle of it. keep leaves
  // req high afterwards, tog scrambles req/data while busy, abort_at stops
  // checking early (for a reset mid-word), chk_gap checks the accept spacing.
  task automatic xfer(input int s, input logic [31:0] w, input bit keep,
                      input bit tog, input int abort_at, input bit chk_gap);
    int  div, n;
    bit  got;
    div = div_of(s);
    data[s] = w;
    req[s]  = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = valid_w[s];
    end
    if (!got) begin
      check_val("accept_timeout", 32'd0, 32'd1);
      req[s] = 1'b0;
      return;
    end
    if (chk_gap) check_val("word_gap", cyc - last_acc, 40*div + 1);
    last_acc = cyc;
    if (!keep) req[s] = 1'b0;
    for (int t = 0; t < 40*div; t++) begin
      if (t > 0) @(negedge clk);
      check_val("txd", 32'(txd_w[s]), 32'(exp_txd(w, t, div)));
      check_val("busy", 32'(busy_w[s]), 32'd1);
      check_val("valid", 32'(valid_w[s]), (t == 0) ? 32'd1 : 32'd0);
      if (tog) begin
        req[s]  = 1'($urandom_range(1, 0));
        data[s] = $urandom;
      end
      if (t == abort_at) return;
    end
    @(negedge clk);
    check_val("end_txd", 32'(txd_w[s]), 32'd1);
    check_val("end_busy", 32'(busy_w[s]), 32'd0);
    check_val("end_valid", 32'(valid_w[s]), 32'd0);
    if (tog) req[s] = 1'b0;
  endtask

  task automatic idle_check(input int s, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_val("idle_txd", 32'(txd_w[s]), 32'd1);
      check_val("idle_busy", 32'(busy_w[s]), 32'd0);
      check_val("idle_valid", 32'(valid_w[s]), 32'd0);
    end
  endtask

  initial begin
    rst = 3'b111;
    req = 3'b100;  // request during reset on the 72 instance must be lost
    for (int i = 0; i < 3; i++) data[i] = $urandom;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("rst_txd", 32'(txd_w[i]), 32'd1);
      check_val("rst_busy", 32'(busy_w[i]), 32'd0);
      check_val("rst_valid", 32'(valid_w[i]), 32'd0);
    end
    rst = 3'b000;
    req = 3'b000;
    idle_check(2, 2);

    // Single word, divider 4
    xfer(0, 32'h1234_5678, 1'b0, 1'b0, -1, 1'b0);
    idle_check(0, 3);

    // Back-to-back with req held high
    xfer(0, 32'hA5A5_0F0F, 1'b1, 1'b0, -1, 1'b0);
    xfer(0, 32'h0000_00FF, 1'b0, 1'b0, -1, 1'b1);
    idle_check(0, 3);

    // Random back-to-back stream
    for (int k = 0; k < 4; k++)
      xfer(0, $urandom, (k < 3), 1'b0, -1, (k > 0));
    idle_check(0, 2);

    // Reset during DATA of byte 2 (bit 3 of byte 2 at t = 96)
    xfer(0, $urandom, 1'b0, 1'b0, 96, 1'b0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check_val("mid_rst_txd", 32'(txd_w[0]), 32'd1);
    check_val("mid_rst_busy", 32'(busy_w[0]), 32'd0);
    check_val("mid_rst_valid", 32'(valid_w[0]), 32'd0);
    idle_check(0, 80);
    xfer(0, $urandom, 1'b0, 1'b0, -1, 1'b0);

    // Minimum divider
    xfer(1, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0);
    xfer(1, 32'h0000_0000, 1'b1, 1'b0, -1, 1'b0);
    xfer(1, $urandom, 1'b0, 1'b0, -1, 1'b1);
    idle_check(1, 3);

    // Request toggled while busy
    xfer(0, $urandom, 1'b0, 1'b1, -1, 1'b0);
    idle_check(0, 5);

    // Default divider
    xfer(2, $urandom, 1'b0, 1'b0, -1, 1'b0);
    idle_check(2, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
